// File: rtl/vmem_arbiter.sv
// Slot arbiter sharing one SRAM between screen fetch and CPU, 2 clk28 per slot.
// Optional ULAplus palette (64x8) enabled with `define ULAPLUS_EN.
module vmem_arbiter (
  input  logic        clk28,
  input  logic        rst,
  input  logic        ck14,
  input  logic        fetch,
  input  logic        fetch_up,
  input  logic [14:0] fetch_addr,
  input  logic [5:0]  up_addr,
  output logic        fetch_allow,
  output logic [7:0]  fetch_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        up_wr,
  input  logic [5:0]  up_waddr,
  input  logic [7:0]  up_wdata,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_oe_n,
  output logic        mem_we_n
);
  typedef enum logic [1:0] {IDLE, SCR, CPU_RD, CPU_WR} state_t;

  state_t     state, state_nxt;
  logic       phase;      // 1 in the second clk28 of a slot
  logic [2:0] starve;
  logic       up_pend;
  logic [7:0] pal_q;
  logic       cpu_slot, cpu_ok, scr_req, force_cpu;

`ifdef ULAPLUS_EN
  logic [7:0] pal [64];
  always_ff @(posedge clk28)
    if (up_wr) pal[up_waddr] <= up_wdata;
  assign pal_q = pal[up_addr];
`else
  logic unused_pal;
  assign unused_pal = ^{up_wr, up_waddr, up_wdata, up_addr};
  assign pal_q = 8'h00;
`endif

  // The CPU slot just ending still has cpu_req high; it must not be regranted.
  always_comb begin
    cpu_slot  = (state == CPU_RD) || (state == CPU_WR);
    cpu_ok    = cpu_req && !cpu_ack && !cpu_slot;
    scr_req   = fetch && !fetch_up;
    force_cpu = (starve == 3'd7);
  end

  always_ff @(posedge clk28)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (ck14) begin
      if (cpu_ok && (force_cpu || !scr_req)) state_nxt = cpu_wr ? CPU_WR : CPU_RD;
      else if (scr_req)                      state_nxt = SCR;
      else                                   state_nxt = IDLE;
    end
  end

  always_comb begin
    mem_oe_n    = !((state == SCR) || (state == CPU_RD));
    mem_we_n    = !((state == CPU_WR) && phase);
    fetch_allow = !force_cpu;
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      phase      <= 1'b0;
      starve     <= 3'd0;
      up_pend    <= 1'b0;
      cpu_ack    <= 1'b0;
      fetch_data <= 8'h00;
      cpu_rdata  <= 8'h00;
      mem_addr   <= 15'd0;
      mem_wdata  <= 8'h00;
    end else begin
      phase   <= !ck14;
      cpu_ack <= ck14 && cpu_slot;
      if (ck14) begin
        if (state == SCR)  fetch_data <= mem_rdata;
        else if (up_pend)  fetch_data <= pal_q;
        if (state == CPU_RD) cpu_rdata <= mem_rdata;
        up_pend <= fetch && fetch_up;
        case (state_nxt)
          SCR:    mem_addr <= fetch_addr;
          CPU_RD: mem_addr <= cpu_addr;
          CPU_WR: begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end
          default: ;
        endcase
        // A forced slot always clears, so fetch_allow drops for one slot only.
        if (state_nxt == CPU_RD || state_nxt == CPU_WR || force_cpu) starve <= 3'd0;
        else if (cpu_ok)                                             starve <= starve + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter: SRAM model, slot-aligned stimulus on negedges.
module tb_vmem_arbiter;
  logic        clk28 = 0, rst = 1, ck14 = 0;
  logic        fetch = 0, fetch_up = 0;
  logic [14:0] fetch_addr = 0;
  logic [5:0]  up_addr = 0;
  logic        fetch_allow;
  logic [7:0]  fetch_data;
  logic        cpu_req = 0, cpu_wr = 0;
  logic [14:0] cpu_addr = 0;
  logic [7:0]  cpu_wdata = 0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        up_wr = 0;
  logic [5:0]  up_waddr = 0;
  logic [7:0]  up_wdata = 0;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_oe_n, mem_we_n;

  int n_vec = 0, n_err = 0;

  vmem_arbiter dut (
    .clk28(clk28), .rst(rst), .ck14(ck14), .fetch(fetch), .fetch_up(fetch_up),
    .fetch_addr(fetch_addr), .up_addr(up_addr), .fetch_allow(fetch_allow),
    .fetch_data(fetch_data), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .up_wr(up_wr),
    .up_waddr(up_waddr), .up_wdata(up_wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  initial forever #5 clk28 = ~clk28;
  initial forever begin @(posedge clk28); #1 ck14 = ~ck14; end

  logic [7:0] sram [32768];
  bit init_done = 0;
  assign mem_rdata = sram[mem_addr];
  always @(posedge clk28) begin
    if (!init_done) begin
      sram[15'h1234] = 8'hA5;
      sram[15'h0100] = 8'h5A;
      init_done = 1;
    end else if (!mem_we_n) sram[mem_addr] = mem_wdata;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Leaves us at the negedge right before a slot boundary edge.
  task automatic sync_slot();
    int k = 0;
    do begin @(negedge clk28); k++; end while (!ck14 && k < 8);
    n_vec++;
    if (ck14 !== 1'b1) begin n_err++; $display("FAIL sync: ck14 got %b want 1", ck14); end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk28);
    n_vec++; if (fetch_allow !== 1'b1) begin n_err++; $display("FAIL rst_fetch_allow got %b want 1", fetch_allow); end
    n_vec++; if (fetch_data !== 8'h00) begin n_err++; $display("FAIL rst_fetch_data got %h want 00", fetch_data); end
    n_vec++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL rst_cpu_rdata got %h want 00", cpu_rdata); end
    n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rst_cpu_ack got %b want 0", cpu_ack); end
    n_vec++; if (mem_addr !== 15'd0) begin n_err++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    n_vec++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL rst_mem_wdata got %h want 00", mem_wdata); end
    n_vec++; if (mem_oe_n !== 1'b1) begin n_err++; $display("FAIL rst_oe_n got %b want 1", mem_oe_n); end
    n_vec++; if (mem_we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n got %b want 1", mem_we_n); end
    rst = 0;
  endtask

  task automatic test_scr_fetch();
    sync_slot();
    fetch = 1; fetch_addr = 15'h1234;
    @(negedge clk28); fetch = 0;
    n_vec++; if (mem_oe_n !== 1'b0) begin n_err++; $display("FAIL scr_oe_c1 got %b want 0", mem_oe_n); end
    n_vec++; if (mem_addr !== 15'h1234) begin n_err++; $display("FAIL scr_addr got %h want 1234", mem_addr); end
    @(negedge clk28);
    n_vec++; if (mem_oe_n !== 1'b0) begin n_err++; $display("FAIL scr_oe_c2 got %b want 0", mem_oe_n); end
    n_vec++; if (mem_we_n !== 1'b1) begin n_err++; $display("FAIL scr_we got %b want 1", mem_we_n); end
    @(negedge clk28);
    n_vec++; if (mem_oe_n !== 1'b1) begin n_err++; $display("FAIL scr_oe_end got %b want 1", mem_oe_n); end
    n_vec++; if (fetch_data !== 8'hA5) begin n_err++; $display("FAIL scr_data got %h want a5", fetch_data); end
    n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL scr_no_ack got %b want 0", cpu_ack); end
  endtask

  task automatic test_cpu_write();
    sync_slot();
    cpu_req = 1; cpu_wr = 1; cpu_addr = 15'h0010; cpu_wdata = 8'h3C;
    @(negedge clk28);
    n_vec++; if (mem_we_n !== 1'b1) begin n_err++; $display("FAIL wr_we_c1 got %b want 1", mem_we_n); end
    n_vec++; if (mem_oe_n !== 1'b1) begin n_err++; $display("FAIL wr_oe got %b want 1", mem_oe_n); end
    n_vec++; if (mem_addr !== 15'h0010) begin n_err++; $display("FAIL wr_addr got %h want 0010", mem_addr); end
    n_vec++; if (mem_wdata !== 8'h3C) begin n_err++; $display("FAIL wr_wdata got %h want 3c", mem_wdata); end
    @(negedge clk28);
    n_vec++; if (mem_we_n !== 1'b0) begin n_err++; $display("FAIL wr_we_c2 got %b want 0", mem_we_n); end
    @(negedge clk28);
    n_vec++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack got %b want 1", cpu_ack); end
    n_vec++; if (mem_we_n !== 1'b1) begin n_err++; $display("FAIL wr_we_end got %b want 1", mem_we_n); end
    cpu_req = 0; cpu_wr = 0;
    @(negedge clk28);
    n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_pulse got %b want 0", cpu_ack); end
    sync_slot();
    cpu_req = 1; cpu_addr = 15'h0010;
    @(negedge clk28);
    n_vec++; if (mem_oe_n !== 1'b0) begin n_err++; $display("FAIL rd_oe got %b want 0", mem_oe_n); end
    @(negedge clk28); @(negedge clk28);
    n_vec++; if (cpu_rdata !== 8'h3C) begin n_err++; $display("FAIL rd_data got %h want 3c", cpu_rdata); end
    n_vec++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack got %b want 1", cpu_ack); end
    cpu_req = 0;
  endtask

  task automatic test_starvation();
    sync_slot();
    fetch = 1; fetch_up = 0; fetch_addr = 15'h0100;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 15'h1234;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk28);
      n_vec++; if (mem_addr !== 15'h0100) begin n_err++; $display("FAIL starve_scr_addr slot %0d got %h want 0100", i, mem_addr); end
      n_vec++; if (fetch_allow !== (i < 7)) begin n_err++; $display("FAIL starve_allow slot %0d got %b want %b", i, fetch_allow, (i < 7)); end
      @(negedge clk28);
    end
    @(negedge clk28);
    n_vec++; if (mem_addr !== 15'h1234) begin n_err++; $display("FAIL starve_cpu_addr got %h want 1234", mem_addr); end
    n_vec++; if (fetch_allow !== 1'b1) begin n_err++; $display("FAIL starve_allow_back got %b want 1", fetch_allow); end
    @(negedge clk28); @(negedge clk28);
    n_vec++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL starve_ack got %b want 1", cpu_ack); end
    n_vec++; if (cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL starve_rdata got %h want a5", cpu_rdata); end
    n_vec++; if (mem_addr !== 15'h0100) begin n_err++; $display("FAIL starve_scr_resume got %h want 0100", mem_addr); end
    cpu_req = 0; fetch = 0;
  endtask

  task automatic test_palette();
    logic [7:0] exp_pal;
`ifdef ULAPLUS_EN
    exp_pal = 8'hE0;
`else
    exp_pal = 8'h00;
`endif
    @(negedge clk28); up_wr = 1; up_waddr = 6'd5; up_wdata = 8'hE0;
    @(negedge clk28); up_wr = 0;
    sync_slot();
    fetch = 1; fetch_up = 1; up_addr = 6'd5;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 15'h0010;
    @(negedge clk28); fetch = 0; fetch_up = 0;
    n_vec++; if (mem_addr !== 15'h0010) begin n_err++; $display("FAIL pal_cpu_addr got %h want 0010", mem_addr); end
    n_vec++; if (mem_oe_n !== 1'b0) begin n_err++; $display("FAIL pal_cpu_oe got %b want 0", mem_oe_n); end
    @(negedge clk28); @(negedge clk28);
    n_vec++; if (fetch_data !== exp_pal) begin n_err++; $display("FAIL pal_data got %h want %h", fetch_data, exp_pal); end
    n_vec++; if (cpu_rdata !== 8'h3C) begin n_err++; $display("FAIL pal_cpu_rdata got %h want 3c", cpu_rdata); end
    n_vec++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL pal_cpu_ack got %b want 1", cpu_ack); end
    cpu_req = 0;
  endtask

  task automatic test_reset_midwrite();
    sync_slot();
    cpu_req = 1; cpu_wr = 1; cpu_addr = 15'h0020; cpu_wdata = 8'h77;
    @(negedge clk28); @(negedge clk28);
    n_vec++; if (mem_we_n !== 1'b0) begin n_err++; $display("FAIL mid_we_before got %b want 0", mem_we_n); end
    rst = 1; cpu_req = 0; cpu_wr = 0;
    @(negedge clk28);
    n_vec++; if (mem_we_n !== 1'b1) begin n_err++; $display("FAIL mid_we got %b want 1", mem_we_n); end
    n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL mid_ack got %b want 0", cpu_ack); end
    n_vec++; if (mem_oe_n !== 1'b1) begin n_err++; $display("FAIL mid_oe got %b want 1", mem_oe_n); end
    n_vec++; if (mem_addr !== 15'd0) begin n_err++; $display("FAIL mid_addr got %h want 0", mem_addr); end
    n_vec++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL mid_wdata got %h want 00", mem_wdata); end
    n_vec++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL mid_rdata got %h want 00", cpu_rdata); end
    n_vec++; if (fetch_data !== 8'h00) begin n_err++; $display("FAIL mid_fdata got %h want 00", fetch_data); end
    n_vec++; if (fetch_allow !== 1'b1) begin n_err++; $display("FAIL mid_allow got %b want 1", fetch_allow); end
    @(negedge clk28);
    n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL mid_ack_late got %b want 0", cpu_ack); end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_scr_fetch();
    test_cpu_write();
    test_starvation();
    test_palette();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vmem_arbiter.md
VMEM_ARBITER -- requirements
Module: vmem_arbiter

Interface
REQ-001 The block SHALL have one clock, clk28; reset is synchronous and active-high, port rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk28  in  1  28 MHz system clock
- rst  in  1  synchronous active-high reset
- ck14  in  1  slot strobe; one memory slot = 2 clk28 cycles, boundary at each clk28 edge with ck14=1
- fetch  in  1  screen fetch request for the next slot
- fetch_up  in  1  qualifies fetch as a palette (ULAplus) read
- fetch_addr  in  15  screen SRAM address
- up_addr  in  6  palette read index
- fetch_allow  out  1  screen may issue fetch
- fetch_data  out  8  screen read data
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_wr  in  1  1=write, 0=read
- cpu_addr  in  15  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data
- cpu_ack  out  1  one-clk28 completion pulse
- up_wr  in  1  palette write strobe, one clk28
- up_waddr  in  6  palette write index
- up_wdata  in  8  palette write data
- mem_addr  out  15  SRAM address
- mem_wdata  out  8  SRAM write data
- mem_rdata  in  8  SRAM read data
- mem_oe_n  out  1  SRAM output enable, active low
- mem_we_n  out  1  SRAM write enable, active low

Function
REQ-003 Slot owner SHALL be decided at each slot boundary; FSM states IDLE, SCR, CPU_RD, CPU_WR.
REQ-004 Priority: fetch&&!fetch_up -> SCR; else cpu_req -> CPU_RD/CPU_WR per cpu_wr; else IDLE.
REQ-005 mem_addr SHALL be registered at the boundary from fetch_addr (SCR) or cpu_addr (CPU_*); held in IDLE.
REQ-006 mem_oe_n SHALL be 0 for both cycles of SCR and CPU_RD slots, 1 otherwise.
REQ-007 mem_we_n SHALL be 0 only in the second clk28 of a CPU_WR slot; mem_wdata latched from cpu_wdata at the boundary.
REQ-008 At the boundary ending an SCR slot, fetch_data SHALL load mem_rdata; held until the next load.
REQ-009 At the boundary ending a CPU_RD slot, cpu_rdata SHALL load mem_rdata; cpu_ack SHALL pulse for the following clk28 after any CPU_* slot.
REQ-010 A CPU request SHALL NOT be granted again while cpu_ack is high.
REQ-011 cpu_req dropped mid-slot: slot completes, cpu_ack still pulses.
REQ-012 Starvation counter (3 bits) SHALL increment per boundary with cpu_req pending and not granted, clear on CPU grant; on reaching 7, fetch_allow SHALL go 0 for exactly one slot, forcing a CPU grant.
REQ-013 fetch_allow SHALL be 1 at all other times.
REQ-014 fetch&&fetch_up SHALL NOT occupy SRAM; the same slot SHALL be available to the CPU.

Reset
REQ-015 Reset SHALL set: state IDLE, fetch_allow=1, fetch_data=0, cpu_rdata=0, cpu_ack=0, mem_addr=0, mem_wdata=0, mem_oe_n=1, mem_we_n=1, starvation counter 0.
REQ-016 Reset asserted mid-slot SHALL abort the access; mem_we_n=1 from the next edge, no cpu_ack.
REQ-017 Palette contents SHALL NOT be reset.

Configuration
REQ-018 Macro ULAPLUS_EN defined: 64x8 palette; fetch_up read loads fetch_data with palette[up_addr] at the slot-end boundary; up_wr writes at its edge; same-index read/write in one edge returns old data.
REQ-019 ULAPLUS_EN undefined: no palette storage; fetch_up reads load fetch_data=8'h00; up_wr ignored.

Verification
REQ-020 SRAM model 0x1234=0xA5, fetch at addr 0x1234 -> mem_oe_n=0 two cycles, fetch_data=0xA5 after slot end.
REQ-021 cpu_req write 0x0010<-0x3C with fetch idle -> mem_we_n low one clk28, cpu_ack one pulse, readback 0x3C.
REQ-022 fetch held continuously plus pending cpu_req -> fetch_allow low one slot after 7 denied slots, CPU served, counter clears.
REQ-023 ULAPLUS_EN: up_wr idx 5=0xE0, then fetch_up idx 5 -> fetch_data=0xE0, concurrent CPU read served same slot; without macro -> 0x00.
REQ-024 rst pulsed during second cycle of CPU_WR -> mem_we_n=1 next edge, no cpu_ack, all outputs at reset values.
